aurora_link_mgr: RTL and testbench

- Multi-channel Aurora 8b10b link bring-up and supervision controller in the init_clk domain.
- Sits beside N_CH Aurora wrapper instances and drives each instance's gt_reset and reset inputs through a timed power-on sequence.
- Monitors each instance's channel_up, retrains on timeout or link drop, and declares permanent failure after MAX_RETRY attempts.
- Exposes per-channel status and saturating drop/retry counters for the system register map.

---
 rtl/aurora_link_pkg.sv | 35 +++
 rtl/aurora_link_ch_fsm.sv | 150 +++++++++++++++
 rtl/aurora_link_mgr.sv | 51 +++++
 tb/tb_aurora_link_mgr.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/aurora_link_pkg.sv
// Shared types and helpers for the Aurora link bring-up/supervision controller.
package aurora_link_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_GT_RST  = 3'd1,
    ST_SYS_RST = 3'd2,
    ST_WAIT_UP = 3'd3,
    ST_LINKED  = 3'd4,
    ST_FAIL    = 3'd5
  } link_state_e;

  // Bits needed to hold values 0..v-1; never less than 1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned w;
    w = 0;
    while ((64'd1 << w) < 64'(v)) w++;
    return (w == 0) ? 1 : w;
  endfunction

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Increment v, holding at the all-ones value of a w-bit counter.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] top;
    top = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    return (v >= top) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/aurora_link_ch_fsm.sv
// Single-channel Aurora bring-up FSM: reset sequencing, channel_up supervision,
// retry/fail policy and saturating statistics counters.
module aurora_link_ch_fsm
  import aurora_link_pkg::*;
#(
  parameter int unsigned GT_RST_CYC  = 5000,
  parameter int unsigned SYS_RST_CYC = 1000,
  parameter int unsigned UP_TIMEOUT  = 2000000,
  parameter int unsigned DROP_FILT   = 16,
  parameter int unsigned MAX_RETRY   = 3,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             en_i,
  input  logic             retrain_i,
  input  logic             channel_up_i,
  input  logic             clr_cnt_i,
  output logic             gt_reset_o,
  output logic             reset_o,
  output logic             link_ok_o,
  output logic             fail_o,
  output logic [CNT_W-1:0] drop_cnt_o,
  output logic [CNT_W-1:0] retry_cnt_o
);

  localparam int unsigned TMR_W = clog2(max3(GT_RST_CYC, SYS_RST_CYC, UP_TIMEOUT) + 1);
  localparam int unsigned LOW_W = clog2(DROP_FILT + 1);
  localparam int unsigned ATT_W = clog2(MAX_RETRY + 1);

  link_state_e      state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d, timer_inc;
  logic [LOW_W-1:0] low_q, low_d, low_inc;
  logic [ATT_W-1:0] attempt_q, attempt_d, attempt_inc;
  logic [CNT_W-1:0] drop_q, drop_d, retry_q, retry_d;
  logic [1:0]       sync_q, sync_d;
  logic             gt_reset_q, gt_reset_d, reset_q, reset_d;
  logic             link_ok_q, link_ok_d, fail_q, fail_d;
  logic             up_s;

  assign up_s        = sync_q[1];
  assign timer_inc   = timer_q + 1'b1;
  assign low_inc     = low_q + 1'b1;
  assign attempt_inc = attempt_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    timer_d   = '0;
    low_d     = '0;
    attempt_d = attempt_q;
    drop_d    = drop_q;
    retry_d   = retry_q;
    sync_d    = {sync_q[0], channel_up_i};

    if (!en_i) begin
      state_d   = ST_IDLE;
      attempt_d = '0;
    end else if (retrain_i && (state_q != ST_IDLE)) begin
      state_d   = ST_GT_RST;
      attempt_d = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d   = ST_GT_RST;
          attempt_d = '0;
        end
        ST_GT_RST: begin
          if (timer_inc == TMR_W'(GT_RST_CYC)) state_d = ST_SYS_RST;
          else timer_d = timer_inc;
        end
        ST_SYS_RST: begin
          if (timer_inc == TMR_W'(SYS_RST_CYC)) state_d = ST_WAIT_UP;
          else timer_d = timer_inc;
        end
        ST_WAIT_UP: begin
          // A link coming up on the last timeout cycle still counts as success.
          if (up_s) begin
            state_d   = ST_LINKED;
            attempt_d = '0;
          end else if (timer_inc == TMR_W'(UP_TIMEOUT)) begin
            retry_d   = CNT_W'(sat_inc(32'(retry_q), CNT_W));
            attempt_d = attempt_inc;
            state_d   = (attempt_inc == ATT_W'(MAX_RETRY)) ? ST_FAIL : ST_GT_RST;
          end else begin
            timer_d = timer_inc;
          end
        end
        ST_LINKED: begin
          if (!up_s) begin
            if (low_inc == LOW_W'(DROP_FILT)) begin
              drop_d    = CNT_W'(sat_inc(32'(drop_q), CNT_W));
              state_d   = ST_GT_RST;
              attempt_d = '0;
            end else begin
              low_d = low_inc;
            end
          end
        end
        ST_FAIL: state_d = ST_FAIL;
        default: state_d = ST_IDLE;
      endcase
    end

    if (clr_cnt_i) begin
      drop_d  = '0;
      retry_d = '0;
    end

    gt_reset_d = (state_d == ST_IDLE) || (state_d == ST_GT_RST) || (state_d == ST_FAIL);
    reset_d    = gt_reset_d || (state_d == ST_SYS_RST);
    link_ok_d  = (state_d == ST_LINKED);
    fail_d     = (state_d == ST_FAIL);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_IDLE;
      timer_q    <= '0;
      low_q      <= '0;
      attempt_q  <= '0;
      drop_q     <= '0;
      retry_q    <= '0;
      sync_q     <= '0;
      gt_reset_q <= 1'b1;
      reset_q    <= 1'b1;
      link_ok_q  <= 1'b0;
      fail_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      low_q      <= low_d;
      attempt_q  <= attempt_d;
      drop_q     <= drop_d;
      retry_q    <= retry_d;
      sync_q     <= sync_d;
      gt_reset_q <= gt_reset_d;
      reset_q    <= reset_d;
      link_ok_q  <= link_ok_d;
      fail_q     <= fail_d;
    end
  end

  assign gt_reset_o  = gt_reset_q;
  assign reset_o     = reset_q;
  assign link_ok_o   = link_ok_q;
  assign fail_o      = fail_q;
  assign drop_cnt_o  = drop_q;
  assign retry_cnt_o = retry_q;

endmodule

// File: rtl/aurora_link_mgr.sv
// Multi-channel Aurora link manager: one independent supervisor FSM per channel.
module aurora_link_mgr
  import aurora_link_pkg::*;
#(
  parameter int unsigned N_CH        = 4,
  parameter int unsigned GT_RST_CYC  = 5000,
  parameter int unsigned SYS_RST_CYC = 1000,
  parameter int unsigned UP_TIMEOUT  = 2000000,
  parameter int unsigned DROP_FILT   = 16,
  parameter int unsigned MAX_RETRY   = 3,
  parameter int unsigned CNT_W       = 8
) (
  input  logic                  init_clk_i,
  input  logic                  rst_n_i,
  input  logic [N_CH-1:0]       ch_en_i,
  input  logic [N_CH-1:0]       retrain_i,
  input  logic [N_CH-1:0]       channel_up_i,
  output logic [N_CH-1:0]       gt_reset_o,
  output logic [N_CH-1:0]       reset_o,
  output logic [N_CH-1:0]       link_ok_o,
  output logic [N_CH-1:0]       fail_o,
  output logic [N_CH*CNT_W-1:0] drop_cnt_o,
  output logic [N_CH*CNT_W-1:0] retry_cnt_o,
  input  logic                  clr_cnt_i
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    aurora_link_ch_fsm #(
      .GT_RST_CYC (GT_RST_CYC),
      .SYS_RST_CYC(SYS_RST_CYC),
      .UP_TIMEOUT (UP_TIMEOUT),
      .DROP_FILT  (DROP_FILT),
      .MAX_RETRY  (MAX_RETRY),
      .CNT_W      (CNT_W)
    ) u_ch (
      .clk_i       (init_clk_i),
      .rst_n_i     (rst_n_i),
      .en_i        (ch_en_i[i]),
      .retrain_i   (retrain_i[i]),
      .channel_up_i(channel_up_i[i]),
      .clr_cnt_i   (clr_cnt_i),
      .gt_reset_o  (gt_reset_o[i]),
      .reset_o     (reset_o[i]),
      .link_ok_o   (link_ok_o[i]),
      .fail_o      (fail_o[i]),
      .drop_cnt_o  (drop_cnt_o[i*CNT_W +: CNT_W]),
      .retry_cnt_o (retry_cnt_o[i*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_aurora_link_mgr.sv
// Bench for aurora_link_mgr: directed bring-up/fault scenarios, then random traffic,
// every cycle compared against a timestamp-based behavioural model.
module tb_aurora_link_mgr;

  localparam int unsigned N_CH = 2;
  localparam int unsigned GT   = 8;
  localparam int unsigned SYS  = 4;
  localparam int unsigned UPT  = 20;
  localparam int unsigned DF   = 3;
  localparam int unsigned MR   = 2;
  localparam int unsigned CW   = 4;
  localparam int unsigned CMAX = (1 << CW) - 1;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [N_CH-1:0]     ch_en, retrain, ch_up;
  logic                clr;
  logic [N_CH-1:0]     gt_reset_o, reset_o, link_ok_o, fail_o;
  logic [N_CH*CW-1:0]  drop_cnt_o, retry_cnt_o;

  always #5 clk = ~clk;

  aurora_link_mgr #(
    .N_CH(N_CH), .GT_RST_CYC(GT), .SYS_RST_CYC(SYS), .UP_TIMEOUT(UPT),
    .DROP_FILT(DF), .MAX_RETRY(MR), .CNT_W(CW)
  ) dut (
    .init_clk_i  (clk),
    .rst_n_i     (rst_n),
    .ch_en_i     (ch_en),
    .retrain_i   (retrain),
    .channel_up_i(ch_up),
    .gt_reset_o  (gt_reset_o),
    .reset_o     (reset_o),
    .link_ok_o   (link_ok_o),
    .fail_o      (fail_o),
    .drop_cnt_o  (drop_cnt_o),
    .retry_cnt_o (retry_cnt_o),
    .clr_cnt_i   (clr)
  );

  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: phase plus entry timestamp per channel.
  typedef enum {P_OFF, P_GT, P_SYS, P_WAIT, P_UP, P_DEAD} phase_t;
  phase_t      ph      [N_CH];
  int unsigned t0      [N_CH];
  int unsigned lasthi  [N_CH];
  int unsigned tries   [N_CH];
  int unsigned drops   [N_CH];
  int unsigned retries [N_CH];
  bit          hist_old[N_CH];
  bit          hist_new[N_CH];
  int unsigned ncyc = 0;

  task automatic model_edge();
    ncyc++;
    for (int c = 0; c < N_CH; c++) begin
      bit s;
      s = hist_old[c];
      hist_old[c] = hist_new[c];
      hist_new[c] = ch_up[c];
      if (!rst_n) begin
        ph[c] = P_OFF; tries[c] = 0; drops[c] = 0; retries[c] = 0;
        hist_old[c] = 0; hist_new[c] = 0;
      end else begin
        if (!ch_en[c]) begin
          ph[c] = P_OFF;
        end else if (retrain[c] && ph[c] != P_OFF) begin
          ph[c] = P_GT; t0[c] = ncyc; tries[c] = 0;
        end else begin
          case (ph[c])
            P_OFF: begin ph[c] = P_GT; t0[c] = ncyc; tries[c] = 0; end
            P_GT:  if (ncyc - t0[c] == GT)  begin ph[c] = P_SYS; t0[c] = ncyc; end
            P_SYS: if (ncyc - t0[c] == SYS) begin ph[c] = P_WAIT; t0[c] = ncyc; end
            P_WAIT: begin
              if (s) begin
                ph[c] = P_UP; tries[c] = 0; lasthi[c] = ncyc;
              end else if (ncyc - t0[c] == UPT) begin
                retries[c] = (retries[c] >= CMAX) ? CMAX : retries[c] + 1;
                tries[c]++;
                if (tries[c] == MR) ph[c] = P_DEAD;
                else begin ph[c] = P_GT; t0[c] = ncyc; end
              end
            end
            P_UP: begin
              if (s) lasthi[c] = ncyc;
              else if (ncyc - lasthi[c] == DF) begin
                drops[c] = (drops[c] >= CMAX) ? CMAX : drops[c] + 1;
                ph[c] = P_GT; t0[c] = ncyc; tries[c] = 0;
              end
            end
            default: ;
          endcase
        end
        if (clr) begin drops[c] = 0; retries[c] = 0; end
      end
    end
  endtask

  task automatic compare_all();
    for (int c = 0; c < N_CH; c++) begin
      check($sformatf("gt_reset[%0d]", c), gt_reset_o[c],
            (ph[c] == P_OFF || ph[c] == P_GT || ph[c] == P_DEAD) ? 1 : 0);
      check($sformatf("reset[%0d]", c), reset_o[c],
            (ph[c] == P_OFF || ph[c] == P_GT || ph[c] == P_SYS || ph[c] == P_DEAD) ? 1 : 0);
      check($sformatf("link_ok[%0d]", c), link_ok_o[c], (ph[c] == P_UP) ? 1 : 0);
      check($sformatf("fail[%0d]", c), fail_o[c], (ph[c] == P_DEAD) ? 1 : 0);
      check($sformatf("drop_cnt[%0d]", c), drop_cnt_o[c*CW +: CW], drops[c]);
      check($sformatf("retry_cnt[%0d]", c), retry_cnt_o[c*CW +: CW], retries[c]);
    end
  endtask

  task automatic run(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      model_edge();
      #1;
      compare_all();
    end
  endtask

  int unsigned seg_len;
  int unsigned mode   [N_CH];
  int unsigned glitch [N_CH];
  bit          seg_en [N_CH];

  initial begin
    rst_n = 1'b0; ch_en = '0; retrain = '0; ch_up = '0; clr = 1'b0;
    run(3);
    check("rst_gt_reset", gt_reset_o, 2'b11);
    check("rst_reset", reset_o, 2'b11);

    // Bring-up of channel 0; channel 1 stays disabled.
    rst_n = 1'b1; ch_en = 2'b01;
    run(8);  check("bu_gt_hold", gt_reset_o[0], 1);
    run(1);  check("bu_gt_rel", gt_reset_o[0], 0); check("bu_sys_hold", reset_o[0], 1);
    run(3);  check("bu_sys_hold2", reset_o[0], 1);
    run(1);  check("bu_sys_rel", reset_o[0], 0);
    run(9);  ch_up[0] = 1'b1;
    run(2);  check("bu_link_early", link_ok_o[0], 0);
    run(1);  check("bu_link", link_ok_o[0], 1);
    check("bu_ch1_idle", {gt_reset_o[1], reset_o[1]}, 2'b11);

    // Drop filter: 2-cycle glitch ignored, 3-cycle low run is a drop.
    ch_up[0] = 1'b0; run(2); ch_up[0] = 1'b1; run(4);
    check("df_glitch", link_ok_o[0], 1);
    ch_up[0] = 1'b0; run(3); ch_up[0] = 1'b1; run(2);
    check("df_drop_link", link_ok_o[0], 0);
    check("df_drop_gt", gt_reset_o[0], 1);
    check("df_drop_cnt", drop_cnt_o[3:0], 1);
    run(20);
    check("df_relink", link_ok_o[0], 1);

    // Saturation, then clear coincident with a drop increment.
    for (int k = 0; k < 16; k++) begin
      ch_up[0] = 1'b0; run(3); ch_up[0] = 1'b1; run(20);
    end
    check("sat_drop", drop_cnt_o[3:0], CMAX);
    ch_up[0] = 1'b0; run(3); ch_up[0] = 1'b1; run(1);
    clr = 1'b1; run(1); clr = 1'b0;
    check("clr_vs_inc", drop_cnt_o[3:0], 0);
    run(20);

    // Two timeouts lead to FAIL; retrain recovers.
    ch_up[0] = 1'b0; retrain[0] = 1'b1; run(1); retrain[0] = 1'b0;
    run(63); check("to_not_yet", fail_o[0], 0);
    run(1);
    check("to_fail", fail_o[0], 1);
    check("to_retry", retry_cnt_o[3:0], 2);
    check("to_gt", gt_reset_o[0], 1);
    retrain[0] = 1'b1; run(1); retrain[0] = 1'b0;
    check("rt_fail_clr", fail_o[0], 0);
    check("rt_gt", gt_reset_o[0], 1);

    // Reset while in SYS_RST.
    run(9);
    check("mid_in_sys", {gt_reset_o[0], reset_o[0]}, 2'b01);
    rst_n = 1'b0; run(1); rst_n = 1'b1;
    check("mid_rst_res", {gt_reset_o[0], reset_o[0]}, 2'b11);
    check("mid_rst_cnt", retry_cnt_o[3:0], 0);

    // Disable beats retrain: channel lands in IDLE, so re-enable restarts the full sequence.
    run(10);
    ch_en[0] = 1'b0; retrain[0] = 1'b1; run(1);
    ch_en[0] = 1'b1; retrain[0] = 1'b0;
    run(8); check("dis_gt_hold", gt_reset_o[0], 1);
    run(1); check("dis_gt_rel", gt_reset_o[0], 0);

    // Random traffic on both channels.
    for (int seg = 0; seg < 40; seg++) begin
      seg_len = $urandom_range(40, 150);
      for (int c = 0; c < N_CH; c++) begin
        mode[c]   = $urandom_range(0, 3);
        glitch[c] = 0;
        seg_en[c] = ($urandom_range(0, 7) != 0);
      end
      for (int unsigned i = 0; i < seg_len; i++) begin
        for (int c = 0; c < N_CH; c++) begin
          case (mode[c])
            0: ch_up[c] = 1'b0;
            1: ch_up[c] = 1'b1;
            2: begin
              if (glitch[c] != 0) begin
                ch_up[c] = 1'b0;
                glitch[c]--;
              end else begin
                ch_up[c] = 1'b1;
                if ($urandom_range(0, 11) == 0) glitch[c] = $urandom_range(1, 4);
              end
            end
            default: ch_up[c] = 1'($urandom_range(0, 1));
          endcase
          retrain[c] = ($urandom_range(0, 149) == 0);
          ch_en[c]   = seg_en[c] && ($urandom_range(0, 399) != 0);
        end
        clr   = ($urandom_range(0, 999) == 0);
        rst_n = ($urandom_range(0, 1999) != 0);
        run(1);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, errors);
    $finish;
  end

endmodule
